// File: rtl/oled_layer_scheduler_if.sv
// Bus bundle between the layer generators / config requester and oled_layer_scheduler.
// The master modport is the requester side; the slave modport is the scheduler.
interface oled_layer_scheduler_if #(
  parameter int NUM_LAYERS = 4
);
  localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic                    frame_begin;
  logic [16*NUM_LAYERS-1:0] layer_colour;
  logic                    cfg_valid;
  logic [NUM_LAYERS-1:0]   cfg_mask;
  logic                    cfg_ready;
  logic                    flash_req;
  logic [SEL_W-1:0]        flash_sel;
  logic [15:0]             pixel_colour;
  logic [NUM_LAYERS-1:0]   active_mask;
  logic [7:0]              frame_count;
  logic                    flash_active;

  modport master (
    output frame_begin, layer_colour, cfg_valid, cfg_mask, flash_req, flash_sel,
    input  cfg_ready, pixel_colour, active_mask, frame_count, flash_active
  );

  modport slave (
    input  frame_begin, layer_colour, cfg_valid, cfg_mask, flash_req, flash_sel,
    output cfg_ready, pixel_colour, active_mask, frame_count, flash_active
  );
endinterface

// File: rtl/oled_layer_scheduler.sv
// Per-pixel layer arbiter with frame-synchronous mask updates and hit-flash effect.
// Define OLED_SCHED_FLASH_EN to compile in the flash FSM and FLASH_COLOUR substitution.
module oled_layer_scheduler #(
  parameter int          NUM_LAYERS   = 4,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [15:0] FLASH_COLOUR = 16'hFFFF,
  parameter logic [15:0] TRANSPARENT  = 16'h0000
) (
  input logic clk,
  input logic reset_n,
  oled_layer_scheduler_if.slave bus
);
  localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [15:0]           r_pixel;
  logic [NUM_LAYERS-1:0] r_active;
  logic [NUM_LAYERS-1:0] r_pend_mask;
  logic                  r_pend_full;
  logic [7:0]            r_frame_count;

  logic                  w_xfer;
  logic                  w_win_found;
  logic [SEL_W-1:0]      w_win_idx;
  logic [15:0]           w_win_col;
  logic                  w_flash_hit;
  logic [15:0]           w_compose;

  assign w_xfer = bus.cfg_valid && !r_pend_full;

  // Lowest index wins; a layer showing TRANSPARENT yields to the next one.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_win_col   = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!w_win_found && r_active[i] && (bus.layer_colour[16*i +: 16] != TRANSPARENT)) begin
        w_win_found = 1'b1;
        w_win_idx   = SEL_W'(i);
        w_win_col   = bus.layer_colour[16*i +: 16];
      end
    end
  end

  always_comb begin
    w_compose = '0;
    if (w_win_found) begin
      w_compose = w_flash_hit ? FLASH_COLOUR : w_win_col;
    end
  end

  // Same-cycle transfer and frame_begin bypasses the slot, so cfg_ready never drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pixel       <= '0;
      r_active      <= '1;
      r_pend_mask   <= '0;
      r_pend_full   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_pixel <= w_compose;
      if (bus.frame_begin) begin
        r_frame_count <= r_frame_count + 8'd1;
        if (w_xfer) begin
          r_active <= bus.cfg_mask;
        end else if (r_pend_full) begin
          r_active    <= r_pend_mask;
          r_pend_full <= 1'b0;
        end
      end else if (w_xfer) begin
        r_pend_mask <= bus.cfg_mask;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign bus.pixel_colour = r_pixel;
  assign bus.active_mask  = r_active;
  assign bus.cfg_ready    = !r_pend_full;
  assign bus.frame_count  = r_frame_count;

`ifdef OLED_SCHED_FLASH_EN
  typedef enum logic [1:0] {IDLE, ARMED, FLASHING} flash_state_t;

  flash_state_t     r_state, w_state_nx;
  logic [SEL_W-1:0] r_flash_sel, w_flash_sel_nx;
  logic [7:0]       r_remaining, w_remaining_nx;
  logic             r_phase, w_phase_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_flash_sel <= '0;
      r_remaining <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_flash_sel <= w_flash_sel_nx;
      r_remaining <= w_remaining_nx;
      r_phase     <= w_phase_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_flash_sel_nx = r_flash_sel;
    w_remaining_nx = r_remaining;
    w_phase_nx     = r_phase;
    case (r_state)
      IDLE: begin
        if (bus.flash_req) begin
          w_state_nx     = ARMED;
          w_flash_sel_nx = bus.flash_sel;
        end
      end
      ARMED: begin
        if (bus.frame_begin) begin
          w_state_nx     = FLASHING;
          w_remaining_nx = 8'(FLASH_FRAMES);
          w_phase_nx     = 1'b1;
        end
      end
      FLASHING: begin
        if (bus.frame_begin) begin
          if (r_remaining == 8'd1) begin
            w_state_nx = IDLE;
            w_phase_nx = 1'b0;
          end else begin
            w_remaining_nx = r_remaining - 8'd1;
            w_phase_nx     = !r_phase;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_flash_hit      = (r_state == FLASHING) && r_phase && (w_win_idx == r_flash_sel);
  assign bus.flash_active = (r_state == FLASHING);
`else
  logic w_unused_flash;

  assign w_unused_flash   = ^{bus.flash_req, bus.flash_sel, FLASH_COLOUR, 8'(FLASH_FRAMES)};
  assign w_flash_hit      = 1'b0;
  assign bus.flash_active = 1'b0;
`endif

endmodule
